// File: rtl/song_player_ctrl.sv
// Song ROM fetch/decode/dispatch controller: notes to the tone sequencer, light commands, one loop level.
// Optional: define PLAYER_PAUSE_EN to add the pause input and the PAUSED state.
module song_player_ctrl #(
    parameter int ADDR   = 8,
    parameter int LOOP_W = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            start_mode,
    input  logic            stop,
`ifdef PLAYER_PAUSE_EN
    input  logic            pause,
`endif
    output logic [ADDR-1:0] rom_addr,
    input  logic [11:0]     rom_data,
    output logic [11:0]     seq_cmd,
    output logic            seq_mode,
    output logic            seq_start,
    input  logic            seq_busy,
    output logic            light_on,
    output logic [1:0]      light_sel,
    output logic            playing,
    output logic            loop_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ACK,
        S_DONE
`ifdef PLAYER_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t              r_state,     w_state;
    logic [ADDR-1:0]     r_rom_addr,  w_rom_addr;
    logic [ADDR-1:0]     r_loop_base, w_loop_base;
    logic [LOOP_W-1:0]   r_loop_cnt,  w_loop_cnt;
    logic [11:0]         r_seq_cmd,   w_seq_cmd;
    logic                r_seq_mode,  w_seq_mode;
    logic                r_seq_start, w_seq_start;
    logic                r_light_on,  w_light_on;
    logic [1:0]          r_light_sel, w_light_sel;
    logic                r_loop_err,  w_loop_err;
    logic                r_loop_open, w_loop_open;
    logic [ADDR-1:0]     w_rom_inc;
    state_t              w_resume_state;

    // Address arithmetic wraps at 2^ADDR silently.
    assign w_rom_inc = r_rom_addr + ADDR'(1);

    // Where the player goes after a non-note command or a finished note.
`ifdef PLAYER_PAUSE_EN
    assign w_resume_state = pause ? S_PAUSED : S_FETCH;
`else
    assign w_resume_state = S_FETCH;
`endif

    always_comb begin
        // NOTE: every next-state value gets a default before the case so no path leaves it unassigned (no latches).
        w_state     = r_state;
        w_rom_addr  = r_rom_addr;
        w_loop_base = r_loop_base;
        w_loop_cnt  = r_loop_cnt;
        w_seq_cmd   = r_seq_cmd;
        w_seq_mode  = r_seq_mode;
        w_seq_start = 1'b0;
        w_light_on  = r_light_on;
        w_light_sel = r_light_sel;
        w_loop_err  = r_loop_err;
        w_loop_open = r_loop_open;

        if (r_state != S_IDLE && stop) begin
            // Abort wins over any decode action; address and command are kept.
            w_state    = S_IDLE;
            w_light_on = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state     = S_FETCH;
                        w_seq_mode  = start_mode;
                        w_loop_err  = 1'b0;
                        w_loop_open = 1'b0;
                        w_rom_addr  = '0;
                    end
                end
                S_FETCH: w_state = S_DECODE;
                S_DECODE: begin
                    if (rom_data == 12'hFFF) begin
                        w_light_on = 1'b0;
                        w_state    = S_IDLE;
                    end else begin
                        case (rom_data[11:10])
                            2'b00: begin
                                w_seq_cmd   = rom_data;
                                w_seq_start = 1'b1;
                                w_state     = S_ACK;
                            end
                            2'b01: begin
                                w_light_on  = 1'b1;
                                w_light_sel = rom_data[1:0];
                                w_rom_addr  = w_rom_inc;
                                w_state     = w_resume_state;
                            end
                            2'b10: begin
                                if (r_loop_open) begin
                                    w_loop_err = 1'b1;
                                end else begin
                                    w_loop_base = w_rom_inc;
                                    w_loop_cnt  = rom_data[LOOP_W-1:0];
                                    w_loop_open = 1'b1;
                                end
                                w_rom_addr = w_rom_inc;
                                w_state    = w_resume_state;
                            end
                            default: begin
                                if (!r_loop_open) begin
                                    w_loop_err = 1'b1;
                                    w_rom_addr = w_rom_inc;
                                end else if (r_loop_cnt != '0) begin
                                    w_loop_cnt = r_loop_cnt - LOOP_W'(1);
                                    w_rom_addr = r_loop_base;
                                end else begin
                                    w_loop_open = 1'b0;
                                    w_rom_addr  = w_rom_inc;
                                end
                                w_state = w_resume_state;
                            end
                        endcase
                    end
                end
                S_ACK: begin
                    if (seq_busy) w_state = S_DONE;
                end
                S_DONE: begin
                    if (!seq_busy) begin
                        w_light_on = 1'b0;
                        w_rom_addr = w_rom_inc;
                        w_state    = w_resume_state;
                    end
                end
`ifdef PLAYER_PAUSE_EN
                S_PAUSED: begin
                    if (!pause) w_state = S_FETCH;
                end
`endif
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_loop_base <= '0;
            r_loop_cnt  <= '0;
            r_seq_cmd   <= '0;
            r_seq_mode  <= 1'b0;
            r_seq_start <= 1'b0;
            r_light_on  <= 1'b0;
            r_light_sel <= '0;
            r_loop_err  <= 1'b0;
            r_loop_open <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state     <= w_state;
            r_rom_addr  <= w_rom_addr;
            r_loop_base <= w_loop_base;
            r_loop_cnt  <= w_loop_cnt;
            r_seq_cmd   <= w_seq_cmd;
            r_seq_mode  <= w_seq_mode;
            r_seq_start <= w_seq_start;
            r_light_on  <= w_light_on;
            r_light_sel <= w_light_sel;
            r_loop_err  <= w_loop_err;
            r_loop_open <= w_loop_open;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign seq_cmd   = r_seq_cmd;
    assign seq_mode  = r_seq_mode;
    assign seq_start = r_seq_start;
    assign light_on  = r_light_on;
    assign light_sel = r_light_sel;
    assign loop_err  = r_loop_err;
    assign playing   = (r_state != S_IDLE);

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl with a synchronous ROM model and a sequencer busy model.
// Define PLAYER_PAUSE_EN for both files to also exercise the pause feature.
module tb_song_player_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        start_mode;
    logic        stop;
`ifdef PLAYER_PAUSE_EN
    logic        pause;
`endif
    logic [7:0]  rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [11:0] seq_cmd;
    logic        seq_mode;
    logic        seq_start;
    logic        seq_busy = 1'b0;
    logic        light_on;
    logic [1:0]  light_sel;
    logic        playing;
    logic        loop_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    song_player_ctrl #(.ADDR(8), .LOOP_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .start_mode (start_mode),
        .stop       (stop),
`ifdef PLAYER_PAUSE_EN
        .pause      (pause),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .seq_cmd    (seq_cmd),
        .seq_mode   (seq_mode),
        .seq_start  (seq_start),
        .seq_busy   (seq_busy),
        .light_on   (light_on),
        .light_sel  (light_sel),
        .playing    (playing),
        .loop_err   (loop_err)
    );

    // Synchronous song ROM.
    logic [11:0] rom [256];
    always @(posedge CLK) rom_data <= rom[rom_addr];

    // Sequencer: busy rises the edge after a strobe and stays high busy_len cycles.
    int busy_len = 5;
    int busy_cnt = 0;
    always @(posedge CLK) begin
        if (seq_start === 1'b1) begin
            seq_busy <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            seq_busy <= 1'b0;
            busy_cnt <= 0;
        end
    end

    logic [11:0] strobes [$];
    always @(posedge CLK) if (seq_start === 1'b1) strobes.push_back(seq_cmd);

    task automatic clear_rom(input logic [11:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic do_reset();
        RST = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b0;
        strobes.delete();
    endtask

    // Returns at the negedge after the accepting edge (state FETCH).
    task automatic play(input logic mode);
        start = 1'b1; start_mode = mode;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (playing !== 1'b0 && k < budget) begin @(negedge CLK); k++; end
        n_cmp++;
        if (playing !== 1'b0) begin
            $display("FAIL %s_idle_timeout: playing=%b after %0d cycles, required 0", tag, playing, k);
            n_err++;
        end
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int k = 0;
        while (seq_busy !== 1'b1 && k < budget) begin @(negedge CLK); k++; end
        n_cmp++;
        if (seq_busy !== 1'b1) begin
            $display("FAIL %s_busy_timeout: seq_busy=%b after %0d cycles, required 1", tag, seq_busy, k);
            n_err++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rom_addr, seq_cmd, seq_mode, seq_start, light_on, light_sel, playing, loop_err} !== 27'd0) begin
            $display("FAIL reset_values: got %h, required 0",
                     {rom_addr, seq_cmd, seq_mode, seq_start, light_on, light_sel, playing, loop_err});
            n_err++;
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (playing !== 1'b0) begin
            $display("FAIL idle_no_start: playing=%b, required 0", playing); n_err++;
        end
    endtask

    task automatic test_note();
        logic [11:0] first;
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h012; busy_len = 5;
        play(1'b1);
        n_cmp++;
        if ({playing, rom_addr} !== {1'b1, 8'd0}) begin
            $display("FAIL note_accept: playing/addr=%b/%0d, required 1/0", playing, rom_addr); n_err++;
        end
        @(negedge CLK);
        n_cmp++;
        if (seq_start !== 1'b0) begin
            $display("FAIL note_early_strobe: seq_start=%b, required 0", seq_start); n_err++;
        end
        @(negedge CLK);
        n_cmp++;
        if ({seq_start, seq_cmd} !== {1'b1, 12'h012}) begin
            $display("FAIL note_strobe: start/cmd=%b/%h, required 1/012", seq_start, seq_cmd); n_err++;
        end
        n_cmp++;
        if (seq_mode !== 1'b1) begin
            $display("FAIL note_mode: seq_mode=%b, required 1", seq_mode); n_err++;
        end
        @(negedge CLK);
        n_cmp++;
        if (seq_start !== 1'b0) begin
            $display("FAIL note_strobe_width: seq_start=%b, required 0", seq_start); n_err++;
        end
        wait_idle(40, "note");
        first = (strobes.size() > 0) ? strobes[0] : 12'h000;
        n_cmp++;
        if (strobes.size() !== 1 || first !== 12'h012) begin
            $display("FAIL note_count: strobes=%0d first=%h, required 1/012", strobes.size(), first); n_err++;
        end
        n_cmp++;
        if ({rom_addr, seq_busy} !== {8'd1, 1'b0}) begin
            $display("FAIL note_end: addr/busy=%0d/%b, required 1/0", rom_addr, seq_busy); n_err++;
        end
    endtask

    task automatic test_light();
        logic [11:0] first;
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h402; rom[1] = 12'h030;
        play(1'b0);
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({light_on, light_sel, seq_mode} !== 4'b1_10_0) begin
            $display("FAIL light_set: on/sel/mode=%b/%0d/%b, required 1/2/0", light_on, light_sel, seq_mode); n_err++;
        end
        wait_busy(20, "light");
        n_cmp++;
        if (light_on !== 1'b1) begin
            $display("FAIL light_during_note: light_on=%b, required 1", light_on); n_err++;
        end
        wait_idle(40, "light");
        first = (strobes.size() > 0) ? strobes[0] : 12'h000;
        n_cmp++;
        if ({light_on, light_sel} !== 3'b0_10 || strobes.size() !== 1 || first !== 12'h030) begin
            $display("FAIL light_after_note: on/sel=%b/%0d strobes=%0d first=%h, required 0/2 1/030",
                     light_on, light_sel, strobes.size(), first);
            n_err++;
        end
    endtask

    task automatic test_loop();
        int bad = 0;
        do_reset(); clear_rom(12'hFFF);
        rom[0] = 12'h802; rom[1] = 12'h011; rom[2] = 12'hC00;
        play(1'b0);
        wait_idle(150, "loop");
        foreach (strobes[i]) if (strobes[i] !== 12'h011) bad++;
        n_cmp++;
        if (strobes.size() !== 3 || bad != 0) begin
            $display("FAIL loop_plays: strobes=%0d wrong_cmd=%0d, required 3/0", strobes.size(), bad); n_err++;
        end
        n_cmp++;
        if ({loop_err, rom_addr} !== {1'b0, 8'd3}) begin
            $display("FAIL loop_end: err/addr=%b/%0d, required 0/3", loop_err, rom_addr); n_err++;
        end
    endtask

    task automatic test_loop_err();
        do_reset(); clear_rom(12'hFFF);
        rom[0] = 12'h801; rom[1] = 12'h801; rom[2] = 12'hC00;
        play(1'b0);
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (loop_err !== 1'b0) begin
            $display("FAIL nest_before: loop_err=%b, required 0", loop_err); n_err++;
        end
        @(negedge CLK);
        n_cmp++;
        if (loop_err !== 1'b1) begin
            $display("FAIL nest_set: loop_err=%b, required 1", loop_err); n_err++;
        end
        wait_idle(60, "nest");
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({loop_err, rom_addr} !== {1'b1, 8'd3}) begin
            $display("FAIL nest_hold: err/addr=%b/%0d, required 1/3", loop_err, rom_addr); n_err++;
        end
        // Nested start inside a body with a note: body still plays twice.
        clear_rom(12'hFFF);
        rom[0] = 12'h801; rom[1] = 12'h021; rom[2] = 12'h801; rom[3] = 12'hC00;
        strobes.delete();
        play(1'b0);
        n_cmp++;
        if (loop_err !== 1'b0) begin
            $display("FAIL nest_clear_on_start: loop_err=%b, required 0", loop_err); n_err++;
        end
        wait_idle(80, "nest_body");
        n_cmp++;
        if (strobes.size() !== 2 || loop_err !== 1'b1) begin
            $display("FAIL nest_body: strobes=%0d err=%b, required 2/1", strobes.size(), loop_err); n_err++;
        end
        // Loop end with nothing open.
        clear_rom(12'hFFF); rom[0] = 12'hC00;
        play(1'b0);
        wait_idle(20, "stray_end");
        n_cmp++;
        if ({loop_err, rom_addr} !== {1'b1, 8'd1}) begin
            $display("FAIL stray_end: err/addr=%b/%0d, required 1/1", loop_err, rom_addr); n_err++;
        end
    endtask

    task automatic test_stop();
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h040; rom[1] = 12'h050;
        play(1'b0);
        wait_busy(20, "stop");
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        n_cmp++;
        if ({playing, seq_start, light_on, rom_addr, seq_cmd} !== {3'b000, 8'd0, 12'h040}) begin
            $display("FAIL stop_busy: play/start/light=%b%b%b addr=%0d cmd=%h, required 000/0/040",
                     playing, seq_start, light_on, rom_addr, seq_cmd);
            n_err++;
        end
        repeat (10) @(negedge CLK);
        n_cmp++;
        if (strobes.size() !== 1 || playing !== 1'b0) begin
            $display("FAIL stop_no_restart: strobes=%0d playing=%b, required 1/0", strobes.size(), playing); n_err++;
        end
        // stop in the DECODE cycle of a note beats the dispatch.
        strobes.delete();
        play(1'b0);
        @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (strobes.size() !== 0 || playing !== 1'b0) begin
            $display("FAIL stop_decode: strobes=%0d playing=%b, required 0/0", strobes.size(), playing); n_err++;
        end
        // start and stop together while idle: start wins.
        start = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (playing !== 1'b1) begin
            $display("FAIL start_beats_stop: playing=%b, required 1", playing); n_err++;
        end
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        repeat (8) @(negedge CLK);
        // start during the last reset cycle is ignored.
        RST = 1'b1; start = 1'b1;
        @(negedge CLK);
        RST = 1'b0; start = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (playing !== 1'b0) begin
            $display("FAIL start_at_reset: playing=%b, required 0", playing); n_err++;
        end
    endtask

    task automatic test_reset_mid_note();
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h402; rom[1] = 12'h040;
        play(1'b1);
        wait_busy(20, "rst_mid");
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if ({rom_addr, seq_cmd, seq_mode, seq_start, light_on, light_sel, playing, loop_err} !== 27'd0) begin
            $display("FAIL reset_mid_note: got %h, required 0",
                     {rom_addr, seq_cmd, seq_mode, seq_start, light_on, light_sel, playing, loop_err});
            n_err++;
        end
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [11:0] s0;
        logic [11:0] s1;
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h060; rom[1] = 12'h070; busy_len = 1;
        play(1'b0);
        wait_idle(60, "b2b");
        s0 = (strobes.size() > 0) ? strobes[0] : 12'h000;
        s1 = (strobes.size() > 1) ? strobes[1] : 12'h000;
        n_cmp++;
        if (strobes.size() !== 2 || s0 !== 12'h060 || s1 !== 12'h070) begin
            $display("FAIL back_to_back: strobes=%0d cmds=%h,%h, required 2 060,070", strobes.size(), s0, s1); n_err++;
        end
        busy_len = 5;
    endtask

    task automatic test_wrap();
        int k = 0;
        do_reset(); clear_rom(12'h401); rom[0] = 12'h0A5;
        play(1'b0);
        while (strobes.size() < 2 && k < 1500) begin @(negedge CLK); k++; end
        n_cmp++;
        if (strobes.size() !== 2) begin
            $display("FAIL wrap_timeout: strobes=%0d after %0d cycles, required 2", strobes.size(), k); n_err++;
        end
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        n_cmp++;
        if ({rom_addr, playing} !== {8'd0, 1'b0}) begin
            $display("FAIL wrap_addr: addr/playing=%0d/%b, required 0/0", rom_addr, playing); n_err++;
        end
        repeat (8) @(negedge CLK);
    endtask

`ifdef PLAYER_PAUSE_EN
    task automatic test_pause();
        int k = 0;
        do_reset(); clear_rom(12'hFFF); rom[0] = 12'h080; rom[1] = 12'h090; pause = 1'b0;
        play(1'b0);
        wait_busy(20, "pause");
        pause = 1'b1;
        while (seq_busy !== 1'b0 && k < 20) begin @(negedge CLK); k++; end
        repeat (5) @(negedge CLK);
        n_cmp++;
        if ({playing, rom_addr} !== {1'b1, 8'd1} || strobes.size() !== 1) begin
            $display("FAIL pause_hold: playing/addr=%b/%0d strobes=%0d, required 1/1 1",
                     playing, rom_addr, strobes.size());
            n_err++;
        end
        pause = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({seq_start, seq_cmd} !== {1'b1, 12'h090}) begin
            $display("FAIL pause_resume: start/cmd=%b/%h, required 1/090", seq_start, seq_cmd); n_err++;
        end
        wait_idle(40, "pause");
    endtask
`endif

    initial begin
        RST = 1'b1; start = 1'b0; start_mode = 1'b0; stop = 1'b0;
`ifdef PLAYER_PAUSE_EN
        pause = 1'b0;
`endif
        clear_rom(12'hFFF);
        test_reset();
        test_note();
        test_light();
        test_loop();
        test_loop_err();
        test_stop();
        test_reset_mid_note();
        test_back_to_back();
        test_wrap();
`ifdef PLAYER_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_player_ctrl.md
Name: song_player_ctrl

Overview:
- Fetch-and-dispatch controller for the music path. Steps through the song command ROM, decodes each 12-bit command and hands note commands to the tone sequencer over a start/busy handshake.
- Updates the 7-segment light register from light commands. Supports one level of counted loops and stops at the end marker 12'hFFF.
- Sits between the board buttons, the song ROM and the sequencer.

Parameters:
- ADDR, 8, song ROM address width.
- LOOP_W, 8, width of the loop repeat counter.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- start  input  1  one-cycle play request; ignored unless state is IDLE
- start_mode  input  1  sequencer mode latched on accepted start
- stop  input  1  abort request; honoured in any non-IDLE state
- rom_addr  output  ADDR  song ROM address
- rom_data  input  12  ROM data; valid one cycle after rom_addr changes (synchronous ROM)
- seq_cmd  output  12  command to sequencer; held stable from seq_start until busy falls
- seq_mode  output  1  latched start_mode
- seq_start  output  1  one-cycle dispatch strobe
- seq_busy  input  1  sequencer busy
- light_on  output  1  segment light enable
- light_sel  output  2  selected segment
- playing  output  1  high in every state except IDLE
- loop_err  output  1  sticky; set on nested loop start or on loop end with no open loop

Behaviour:
- Reset values: rom_addr=0, seq_cmd=0, seq_mode=0, seq_start=0, light_on=0, light_sel=0, playing=0, loop_err=0, loop_cnt=0, loop_open=0, state=IDLE.
- Command decode uses cmd[11:10]:
  - 00 = note.
  - 01 = light; light_sel=cmd[1:0].
  - 10 = loop start; repeat count = cmd[LOOP_W-1:0].
  - 11 = loop end.
  - 12'hFFF = end marker; it takes priority over class 11.
- States:
  - IDLE: on start, latch start_mode, clear loop_err/loop_open, set rom_addr=0 -> FETCH.
  - FETCH: wait one cycle for ROM latency -> DECODE.
  - DECODE (acts on rom_data):
    - note: seq_cmd=rom_data, seq_start=1 -> ACK.
    - light: light_on=1, light_sel updated, rom_addr+1 -> FETCH.
    - loop start: if loop_open, set loop_err and treat as no-op; else loop_base=rom_addr+1, loop_cnt=count, loop_open=1. Then rom_addr+1 -> FETCH.
    - loop end: if !loop_open, set loop_err. Else if loop_cnt!=0, decrement loop_cnt and set rom_addr=loop_base. Else clear loop_open and advance rom_addr+1. -> FETCH.
    - FFF: light_on=0 -> IDLE.
  - ACK: seq_start back to 0; wait for seq_busy=1 -> DONE.
  - DONE: wait for seq_busy=0; light_on=0 (a note ends the light); rom_addr+1 -> FETCH.
- Loop count N plays the body N+1 times; N=0 plays it once.
- rom_addr wraps 2^ADDR-1 -> 0 silently; no end marker means playback runs until stop.
- stop in any non-IDLE state: next cycle state=IDLE, seq_start=0, light_on=0; rom_addr and seq_cmd are held. The sequencer is not aborted, so it finishes its current note.
- stop and start in the same cycle while IDLE: start wins. stop has priority over every DECODE action.
- RST mid-note: everything returns to reset values on the next edge regardless of seq_busy.
- Note dispatch latency: seq_start is high in the cycle after DECODE entry, which is 2 cycles after rom_addr is presented.

Optional Feature:
- PLAYER_PAUSE_EN
- Defined: adds input port pause and state PAUSED.
  - If pause=1 when DONE completes, or when FETCH is entered from a non-note command, go to PAUSED instead, holding rom_addr and lights.
  - PAUSED resumes to FETCH when pause=0; stop still goes to IDLE.
  - A note already dispatched always completes.
- Undefined: no pause port and no PAUSED state; behaviour exactly as above.

Test Plan:
- ROM {000:12'h012, 001:12'hFFF}, start, busy high for 5 cycles after strobe -> one seq_start with seq_cmd=12'h012; playing falls once busy=0 and FFF is decoded; rom_addr=1.
- ROM {12'h402, 12'h030, 12'hFFF} -> light_on=1, light_sel=2 after word 0; light_on=0 after the note completes.
- ROM {12'h802, 12'h011, 12'hC00, 12'hFFF} -> exactly 3 seq_start strobes with cmd 12'h011; loop_err=0.
- ROM {12'h801, 12'h801, 12'hC00, 12'hFFF} -> loop_err=1 after the second word; body plays twice; loop_err holds until the next accepted start.
- stop asserted while busy=1 -> IDLE next cycle, no further seq_start even after busy falls; start in the same cycle as a reset release is ignored.
- With PLAYER_PAUSE_EN: pause raised mid-note -> note completes, no seq_start while paused, rom_addr frozen; pause=0 -> next command fetched within 3 cycles.
